// File: rtl/insmem_loader_if.sv
// Byte-stream load port and instruction fetch port of the instruction store loader.
// Macro LOADER_CHECKSUM_EN adds the csum_err status signal.
interface insmem_loader_if #(
  parameter int ADDR_W = 4,
  parameter int WORD_W = 32
);
  // Stream handshake: a byte (with its in_last flag) transfers on every clock
  // edge where in_valid && in_ready; the source holds in_byte/in_last stable
  // while in_valid is high and the transfer has not happened yet.
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_last;
  logic              in_ready;
  logic              restart;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic              load_done;
  logic [ADDR_W:0]   word_count;
  logic              err_overflow;
`ifdef LOADER_CHECKSUM_EN
  logic              csum_err;
`endif

  modport master (
    output in_valid, in_byte, in_last, restart, rd_addr,
    input  in_ready, rd_data, load_done, word_count, err_overflow
`ifdef LOADER_CHECKSUM_EN
    , input csum_err
`endif
  );

  modport slave (
    input  in_valid, in_byte, in_last, restart, rd_addr,
    output in_ready, rd_data, load_done, word_count, err_overflow
`ifdef LOADER_CHECKSUM_EN
    , output csum_err
`endif
  );
endinterface

// File: rtl/insmem_loader.sv
// Assembles a big-endian byte stream into a DEPTH-word instruction store and serves a registered fetch port.
// Macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the csum_err flag.
module insmem_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WORD_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  insmem_loader_if.slave   bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_DONE = 2'd1
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM = 2'd2
`endif
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              err_overflow_q, err_overflow_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              csum_err_q, csum_err_d;
`endif

  logic [WORD_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [WORD_W-1:0] assembled;
  logic [WORD_W-1:0] lane_word;
  logic              accept;
  logic              store_full;
  logic              in_ready;
  logic              load_done;

  assign in_ready   = (state_q != S_DONE);
  assign load_done  = (state_q == S_DONE);
  assign accept     = bus.in_valid && in_ready;
  assign store_full = (word_count_q == FULL_CNT);

  // Lane 0 is the most significant byte; unfilled lanes stay zero, which
  // gives the zero padding of a short final word for free.
  always_comb begin
    lane_word = '0;
    case (byte_idx_q)
      2'd0:    lane_word[31:24] = bus.in_byte;
      2'd1:    lane_word[23:16] = bus.in_byte;
      2'd2:    lane_word[15:8]  = bus.in_byte;
      default: lane_word[7:0]   = bus.in_byte;
    endcase
    assembled = shift_q | lane_word;
  end

  always_comb begin
    state_d        = state_q;
    byte_idx_d     = byte_idx_q;
    shift_d        = shift_q;
    word_count_d   = word_count_q;
    err_overflow_d = err_overflow_q;
    mem_we         = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d         = csum_q;
    csum_err_d     = csum_err_q;
`endif
    rd_data_d = '0;
    if (load_done && ({1'b0, bus.rd_addr} < word_count_q)) begin
      rd_data_d = mem[bus.rd_addr];
    end

    if (bus.restart) begin
      // Any byte offered alongside restart is discarded.
      state_d        = S_LOAD;
      byte_idx_d     = 2'd0;
      shift_d        = '0;
      word_count_d   = '0;
      err_overflow_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_d         = 8'h00;
      csum_err_d     = 1'b0;
`endif
    end else begin
      case (state_q)
        S_LOAD: begin
          if (accept) begin
`ifdef LOADER_CHECKSUM_EN
            csum_d = csum_q ^ bus.in_byte;
`endif
            if (store_full) begin
              err_overflow_d = 1'b1;
            end else if ((byte_idx_q == 2'd3) || bus.in_last) begin
              mem_we       = 1'b1;
              word_count_d = word_count_q + CNT_ONE;
              shift_d      = '0;
              byte_idx_d   = 2'd0;
            end else begin
              shift_d    = assembled;
              byte_idx_d = byte_idx_q + 2'd1;
            end
            if (bus.in_last) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            state_d    = S_DONE;
            csum_err_d = (bus.in_byte != csum_q);
          end
        end
`endif
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_LOAD;
      byte_idx_q     <= 2'd0;
      shift_q        <= '0;
      word_count_q   <= '0;
      err_overflow_q <= 1'b0;
      rd_data_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q         <= 8'h00;
      csum_err_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      byte_idx_q     <= byte_idx_d;
      shift_q        <= shift_d;
      word_count_q   <= word_count_d;
      err_overflow_q <= err_overflow_d;
      rd_data_q      <= rd_data_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q         <= csum_d;
      csum_err_q     <= csum_err_d;
`endif
    end
  end

  // Storage is deliberately not reset; word_count gates what is readable.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[word_count_q[ADDR_W-1:0]] <= assembled;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.load_done    = load_done;
  assign bus.word_count   = word_count_q;
  assign bus.err_overflow = err_overflow_q;
  assign bus.rd_data      = rd_data_q;
`ifdef LOADER_CHECKSUM_EN
  assign bus.csum_err     = csum_err_q;
`endif
  assign dbg_state        = state_q;

endmodule
